sdram_slave_model: RTL and testbench
====================================

SDRAM_SLAVE_MODEL -- requirements
Module: sdram_slave_model

Interface
REQ-001 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-002 Parameter MEM_WORDS, default 4096: backing-store depth in 16-bit words.
REQ-003 Parameter READ_LATENCY, default 3, legal range 1..8: cycles from read acceptance to readdatavalid.
REQ-004 Parameter MAX_PENDING, default 2, legal range 1..READ_LATENCY: maximum number of reads in flight.
REQ-005 Parameter STALL_PERIOD, default 4: accepted commands between injected stalls (used only with the stall macro).
REQ-006 Parameter STALL_CYCLES, default 2: length of one injected stall, in cycles.
REQ-007 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- address, in, 25: word address.
- byteenable_n, in, 2: active-low byte lanes; bit0 selects [7:0], bit1 selects [15:8].
- chipselect, in, 1: command qualifier.
- writedata, in, 16: write data.
- read_n, in, 1: active-low read request.
- write_n, in, 1: active-low write request.
- readdata, out, 16: returned read data.
- readdatavalid, out, 1: readdata is valid this cycle.
- waitrequest, out, 1: command is not accepted this cycle.
- proto_err, out, 1: sticky error flag.

Function
REQ-008 A command SHALL be present when chipselect=1 and exactly one of read_n, write_n is 0.
REQ-009 A command SHALL be accepted in a cycle when it is present and waitrequest=0; the master holds all inputs while waitrequest=1.
REQ-010 waitrequest SHALL be driven only from registered state, with no combinational path from any input.
REQ-011 waitrequest SHALL be 1 whenever pending_count==MAX_PENDING or a stall is active.
REQ-012 An accepted write SHALL update mem[address] only in the byte lanes whose byteenable_n bit is 0; byteenable_n=2'b11 writes nothing.
REQ-013 An accepted read SHALL sample mem[address] in its acceptance cycle.
REQ-014 The sampled read data SHALL be returned with readdatavalid=1 for exactly one cycle, READ_LATENCY cycles after acceptance.
REQ-015 Read returns SHALL be in acceptance order.
REQ-016 A write accepted in cycle N followed by a read of the same address accepted in cycle N+1 SHALL return the newly written data.
REQ-017 readdata SHALL hold its last value when readdatavalid=0.
REQ-018 pending_count SHALL increment on read acceptance and decrement on readdatavalid.
REQ-019 When a read is accepted in the same cycle readdatavalid=1, pending_count SHALL stay unchanged.
REQ-020 If address>=MEM_WORDS, a write SHALL be dropped, a read SHALL return 16'hDEAD with normal timing, and proto_err SHALL set.
REQ-021 chipselect=1 with read_n=0 and write_n=0 in the same cycle SHALL be ignored (not accepted, no memory change, no return) and SHALL set proto_err.
REQ-022 proto_err SHALL clear only on reset.

Reset
REQ-023 During reset, readdata=16'h0000, readdatavalid=0, waitrequest=0 and proto_err=0.
REQ-024 Reset SHALL clear pending_count and the stall counters.
REQ-025 Reads in flight when reset asserts SHALL be discarded and never returned.
REQ-026 Reset SHALL NOT clear memory contents.

Configuration
REQ-027 With macro SDRAM_SLAVE_STALL_EN defined, after every STALL_PERIOD accepted commands, waitrequest SHALL be 1 for the next STALL_CYCLES cycles regardless of pending state.
REQ-028 With SDRAM_SLAVE_STALL_EN undefined, waitrequest SHALL depend only on pending_count and the stall logic SHALL not be present.

Structure
REQ-029 Shared package sdram_if_pkg SHALL hold SDRAM_ADDR_W=25, SDRAM_DATA_W=16 and OOR_READ_DATA=16'hDEAD.
REQ-030 The read return path SHALL be a sub-module rd_latency_pipe: a READ_LATENCY-deep shift register of {valid, data}, cleared by rst_n.

Verification
REQ-031 Write 16'h1234 to address 5 with byteenable_n=2'b00, then read 5 -> readdata=16'h1234 with readdatavalid exactly 3 cycles after read acceptance.
REQ-032 Write 16'hAB00 to address 5 with byteenable_n=2'b01 over the REQ-031 contents, then read 5 -> 16'hAB34.
REQ-033 Issue three back-to-back reads with defaults -> waitrequest=1 in the cycle after the 2nd acceptance, the 3rd read accepted once the 1st returns, returns in order.
REQ-034 Read address 25'd5000 (MEM_WORDS=4096) -> readdata=16'hDEAD after 3 cycles and proto_err=1 until reset.
REQ-035 Assert rst_n low with two reads in flight -> no readdatavalid after reset release; previously written memory unchanged.
REQ-036 With SDRAM_SLAVE_STALL_EN defined, issue 4 writes -> waitrequest=1 for exactly 2 cycles after the 4th acceptance, and the 5th write accepted afterwards.

Source files
------------

// File: rtl/sdram_if_pkg.sv
// -----------------------------------------------------------------------------
// sdram_if_pkg
// Shared definitions for the SDRAM slave model: bus widths, the data value
// returned for out-of-range reads, command decode and byte-lane merge helpers.
// -----------------------------------------------------------------------------
package sdram_if_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;
  localparam logic [SDRAM_DATA_W-1:0] OOR_READ_DATA = 16'hDEAD;

  // Decoded bus command for one cycle.
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_BAD   = 2'd3
  } cmd_e;

  // One slot of the read return pipeline.
  typedef struct packed {
    logic                    valid;
    logic [SDRAM_DATA_W-1:0] data;
  } rd_slot_t;

  // Both strobes low with chipselect is a protocol violation, not a command.
  function automatic cmd_e decode_cmd(input logic cs, input logic rd_n, input logic wr_n);
    cmd_e cmd;
    case ({cs, rd_n, wr_n})
      3'b101:  cmd = CMD_READ;
      3'b110:  cmd = CMD_WRITE;
      3'b100:  cmd = CMD_BAD;
      default: cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

  // Active-low lane enables: a 0 bit takes the new byte, a 1 bit keeps the old one.
  function automatic logic [SDRAM_DATA_W-1:0] merge_bytes(
    input logic [SDRAM_DATA_W-1:0] old_word,
    input logic [SDRAM_DATA_W-1:0] new_word,
    input logic [1:0]              be_n
  );
    logic [SDRAM_DATA_W-1:0] res;
    res[7:0]  = be_n[0] ? old_word[7:0]  : new_word[7:0];
    res[15:8] = be_n[1] ? old_word[15:8] : new_word[15:8];
    return res;
  endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// -----------------------------------------------------------------------------
// rd_latency_pipe
// DEPTH-stage shift register of {valid, data} carrying read returns from the
// acceptance cycle to the bus. A slot's data only moves when its valid moves,
// so the output data holds the last returned word between returns.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears every slot)
//   i_valid     : a read was accepted this cycle
//   i_data      : word sampled for that read
//   o_valid     : return strobe, DEPTH cycles after i_valid
//   o_data      : returned word (held while o_valid=0)
// -----------------------------------------------------------------------------
module rd_latency_pipe
  import sdram_if_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic [SDRAM_DATA_W-1:0] i_data,
  output logic                    o_valid,
  output logic [SDRAM_DATA_W-1:0] o_data
);

  rd_slot_t r_pipe [DEPTH];

  // Shift the return slots one stage per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0].valid <= i_valid;
      if (i_valid) begin
        r_pipe[0].data <= i_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i].valid <= r_pipe[i-1].valid;
        if (r_pipe[i-1].valid) begin
          r_pipe[i].data <= r_pipe[i-1].data;
        end
      end
    end
  end

  assign o_valid = r_pipe[DEPTH-1].valid;
  assign o_data  = r_pipe[DEPTH-1].data;

endmodule

// File: rtl/sdram_slave_model.sv
// -----------------------------------------------------------------------------
// sdram_slave_model
// Avalon-style SDRAM slave with a word-addressed backing store, byte-lane
// writes, fixed read latency and a bounded number of reads in flight.
// Out-of-range accesses and simultaneous read/write strobes set a sticky
// proto_err. Memory contents survive reset.
// Optional feature macro: SDRAM_SLAVE_STALL_EN -- after every STALL_PERIOD
// accepted commands, waitrequest is forced high for STALL_CYCLES cycles.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   address[24:0]       : word address
//   byteenable_n[1:0]   : active-low byte lanes (bit0 -> [7:0], bit1 -> [15:8])
//   chipselect          : command qualifier
//   writedata[15:0]     : write data
//   read_n, write_n     : active-low read / write requests
//   readdata[15:0]      : returned read data, held between returns
//   readdatavalid       : readdata valid this cycle
//   waitrequest         : command not accepted this cycle (registered)
//   proto_err           : sticky protocol / range error
// -----------------------------------------------------------------------------
module sdram_slave_model
  import sdram_if_pkg::*;
#(
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 2,
  parameter int STALL_PERIOD = 4,
  parameter int STALL_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SDRAM_ADDR_W-1:0] address,
  input  logic [1:0]              byteenable_n,
  input  logic                    chipselect,
  input  logic [SDRAM_DATA_W-1:0] writedata,
  input  logic                    read_n,
  input  logic                    write_n,
  output logic [SDRAM_DATA_W-1:0] readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    proto_err
);

  localparam int                      MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [SDRAM_ADDR_W-1:0] MEM_LIMIT = SDRAM_ADDR_W'(MEM_WORDS);
  localparam logic [3:0]              PEND_MAX  = 4'(MAX_PENDING);

  logic [SDRAM_DATA_W-1:0] r_mem [MEM_WORDS];
  logic [3:0]              r_pending;
  logic                    r_waitrequest;
  logic                    r_proto_err;

  cmd_e                    w_cmd;
  logic                    w_in_range;
  logic [MEM_AW-1:0]       w_idx;
  logic                    w_accept_rd;
  logic                    w_accept_wr;
  logic                    w_err_set;
  logic [SDRAM_DATA_W-1:0] w_rd_data;
  logic [3:0]              w_pending_next;
  logic                    w_stall_next;
  logic                    w_pipe_valid;
  logic [SDRAM_DATA_W-1:0] w_pipe_data;

  // Decode the bus, qualify acceptance with the registered waitrequest.
  always_comb begin
    w_cmd       = decode_cmd(chipselect, read_n, write_n);
    w_in_range  = (address < MEM_LIMIT);
    w_idx       = w_in_range ? address[MEM_AW-1:0] : {MEM_AW{1'b0}};
    w_accept_rd = 1'b0;
    w_accept_wr = 1'b0;
    case (w_cmd)
      CMD_READ:  w_accept_rd = !r_waitrequest;
      CMD_WRITE: w_accept_wr = !r_waitrequest;
      default: begin
        w_accept_rd = 1'b0;
        w_accept_wr = 1'b0;
      end
    endcase
    // A write in the previous cycle is already in r_mem, so read-after-write sees it.
    w_rd_data = w_in_range ? r_mem[w_idx] : OOR_READ_DATA;
    w_err_set = (w_cmd == CMD_BAD) || ((w_accept_rd || w_accept_wr) && !w_in_range);
  end

  // Reads in flight: +1 on acceptance, -1 on return, unchanged when both coincide.
  always_comb begin
    w_pending_next = r_pending;
    case ({w_accept_rd, w_pipe_valid})
      2'b10:   w_pending_next = r_pending + 4'd1;
      2'b01:   w_pending_next = r_pending - 4'd1;
      default: w_pending_next = r_pending;
    endcase
  end

`ifdef SDRAM_SLAVE_STALL_EN
  logic [15:0] r_acc_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] w_acc_cnt_next;
  logic [15:0] w_stall_cnt_next;

  // Count accepted commands; every STALL_PERIOD-th one arms a stall window.
  always_comb begin
    w_acc_cnt_next   = r_acc_cnt;
    w_stall_cnt_next = r_stall_cnt;
    if (r_stall_cnt != 16'd0) begin
      w_stall_cnt_next = r_stall_cnt - 16'd1;
    end else begin
      w_stall_cnt_next = r_stall_cnt;
    end
    if (w_accept_rd || w_accept_wr) begin
      if (r_acc_cnt == 16'(STALL_PERIOD - 1)) begin
        w_acc_cnt_next   = 16'd0;
        w_stall_cnt_next = 16'(STALL_CYCLES);
      end else begin
        w_acc_cnt_next = r_acc_cnt + 16'd1;
      end
    end else begin
      w_acc_cnt_next = r_acc_cnt;
    end
    w_stall_next = (w_stall_cnt_next != 16'd0);
  end

  // Stall counters register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt   <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_acc_cnt   <= w_acc_cnt_next;
      r_stall_cnt <= w_stall_cnt_next;
    end
  end
`else
  logic w_unused_stall_cfg;
  assign w_stall_next       = 1'b0;
  assign w_unused_stall_cfg = (STALL_PERIOD > 0) && (STALL_CYCLES > 0);
`endif

  // Control state; waitrequest is computed from next state so it is a pure flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= 4'd0;
      r_waitrequest <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_pending     <= w_pending_next;
      r_waitrequest <= (w_pending_next == PEND_MAX) || w_stall_next;
      r_proto_err   <= r_proto_err | w_err_set;
    end
  end

  // Backing store: no reset so contents survive rst_n; out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (w_accept_wr && w_in_range) begin
      r_mem[w_idx] <= merge_bytes(r_mem[w_idx], writedata, byteenable_n);
    end
  end

  rd_latency_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_accept_rd),
    .i_data  (w_rd_data),
    .o_valid (w_pipe_valid),
    .o_data  (w_pipe_data)
  );

  assign readdata      = w_pipe_data;
  assign readdatavalid = w_pipe_valid;
  assign waitrequest   = r_waitrequest;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_sdram_slave_model.sv
// -----------------------------------------------------------------------------
// tb_sdram_slave_model
// Cycle-level reference model: a word array for memory, a queue of
// {data, due cycle} for reads in flight, and a cycle stamp for stall windows.
// Every cycle the DUT outputs are compared with the model's prediction.
// -----------------------------------------------------------------------------
module tb_sdram_slave_model;

  localparam int LAT  = 3;
  localparam int MAXP = 2;
  localparam int MEMW = 4096;
  localparam int SPER = 4;
  localparam int SCYC = 2;
`ifdef SDRAM_SLAVE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [24:0] address;
  logic [1:0]  byteenable_n;
  logic        chipselect;
  logic [15:0] writedata;
  logic        read_n;
  logic        write_n;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        proto_err;

  sdram_slave_model #(
    .MEM_WORDS    (MEMW),
    .READ_LATENCY (LAT),
    .MAX_PENDING  (MAXP),
    .STALL_PERIOD (SPER),
    .STALL_CYCLES (SCYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .byteenable_n  (byteenable_n),
    .chipselect    (chipselect),
    .writedata     (writedata),
    .read_n        (read_n),
    .write_n       (write_n),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rd_t;

  rd_t         rq[$];
  logic [15:0] m_mem [MEMW];
  logic [15:0] m_rdata;
  logic        m_perr;
  int          m_acc_cnt;
  int          m_stall_until;
  int          cyc;
  int          n_checks;
  int          n_errors;
  string       phase;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (%s, cycle %0d): got %0h, expected %0h", tag, phase, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    m_rdata       = 16'h0000;
    m_perr        = 1'b0;
    m_acc_cnt     = 0;
    m_stall_until = -1;
  endtask

  // Called at #1 after a rising edge: check this cycle, drive it, advance the model.
  task automatic run_cycle(input logic cs, input logic rd_n, input logic wr_n,
                           input logic [24:0] a, input logic [1:0] be_n,
                           input logic [15:0] wd, output logic acc);
    logic        exp_wait;
    logic        exp_rdv;
    logic [15:0] mask;
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
    exp_wait = (rq.size() == MAXP) || (STALL_EN && (cyc <= m_stall_until));
    exp_rdv  = (rq.size() > 0) && (rq[0].due == cyc);
    if (exp_rdv) m_rdata = rq[0].data;
    check_eq("waitrequest",   32'(waitrequest),   32'(exp_wait));
    check_eq("readdatavalid", 32'(readdatavalid), 32'(exp_rdv));
    check_eq("readdata",      32'(readdata),      32'(m_rdata));
    check_eq("proto_err",     32'(proto_err),     32'(m_perr));

    chipselect   = cs;
    read_n       = rd_n;
    write_n      = wr_n;
    address      = a;
    byteenable_n = be_n;
    writedata    = wd;

    acc = cs && (rd_n != wr_n) && !exp_wait;
    if (cs && !rd_n && !wr_n) m_perr = 1'b1;
    if (acc) begin
      if (a >= 25'(MEMW)) m_perr = 1'b1;
      if (!rd_n) begin
        rq.push_back('{data: (a < 25'(MEMW)) ? m_mem[a[11:0]] : 16'hDEAD, due: cyc + LAT});
      end else if (a < 25'(MEMW)) begin
        mask = {be_n[1] ? 8'h00 : 8'hFF, be_n[0] ? 8'h00 : 8'hFF};
        m_mem[a[11:0]] = (m_mem[a[11:0]] & ~mask) | (wd & mask);
      end
      m_acc_cnt++;
      if (m_acc_cnt == SPER) begin
        m_acc_cnt     = 0;
        m_stall_until = cyc + SCYC;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a command and hold it until accepted.
  task automatic issue(input logic is_rd, input int unsigned a, input logic [1:0] be_n, input logic [15:0] wd);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      run_cycle(1'b1, !is_rd, is_rd, 25'(a), be_n, wd, acc);
      tries++;
    end
    check_eq("accept_bound", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b1, 1'b1, 25'd0, 2'b11, 16'h0000, acc);
  endtask

  // Assert reset mid-flight, check reset values, release at #1 after an edge.
  task automatic do_reset();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    rst_n      = 1'b0;
    #1;
    check_eq("rst_readdata",      32'(readdata),      32'h0);
    check_eq("rst_readdatavalid", 32'(readdatavalid), 32'h0);
    check_eq("rst_waitrequest",   32'(waitrequest),   32'h0);
    check_eq("rst_proto_err",     32'(proto_err),     32'h0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hold_rdv", 32'(readdatavalid), 32'h0);
    rst_n = 1'b1;
    cyc   = cyc + 3;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    n_checks     = 0;
    n_errors     = 0;
    cyc          = 0;
    phase        = "reset";
    rst_n        = 1'b0;
    chipselect   = 1'b0;
    read_n       = 1'b1;
    write_n      = 1'b1;
    address      = 25'd0;
    byteenable_n = 2'b11;
    writedata    = 16'h0000;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    phase = "init";
    for (int i = 0; i < 32; i++) issue(1'b0, i, 2'b00, 16'($urandom));

    phase = "random";
    for (int k = 0; k < 200; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2)      idle($urandom_range(1, 3));
      else if (sel < 6) issue(1'b0, $urandom_range(0, 31), 2'($urandom_range(0, 3)), 16'($urandom));
      else              issue(1'b1, $urandom_range(0, 31), 2'b11, 16'h0000);
    end
    idle(6);

    phase = "full_write";
    issue(1'b0, 5, 2'b00, 16'h1234);
    issue(1'b1, 5, 2'b11, 16'h0000);
    idle(5);

    phase = "byte_lane";
    issue(1'b0, 5, 2'b01, 16'hAB00);
    issue(1'b1, 5, 2'b11, 16'h0000);
    idle(5);

    phase = "back_to_back";
    issue(1'b0, 6, 2'b00, 16'h5A5A);
    issue(1'b1, 5, 2'b11, 16'h0000);
    issue(1'b1, 6, 2'b11, 16'h0000);
    issue(1'b1, 5, 2'b11, 16'h0000);
    idle(6);

    phase = "stall";
    for (int i = 0; i < 5; i++) issue(1'b0, 8 + i, 2'b00, 16'(16'h1000 + i));
    idle(4);

    phase = "out_of_range";
    issue(1'b1, 5000, 2'b11, 16'h0000);
    idle(5);
    issue(1'b0, 5000, 2'b00, 16'hFFFF);
    issue(1'b1, 5, 2'b11, 16'h0000);
    idle(5);

    phase = "reset_in_flight";
    issue(1'b0, 7, 2'b00, 16'hBEEF);
    issue(1'b1, 7, 2'b11, 16'h0000);
    issue(1'b1, 5, 2'b11, 16'h0000);
    do_reset();
    idle(6);
    issue(1'b1, 7, 2'b11, 16'h0000);
    issue(1'b1, 5, 2'b11, 16'h0000);
    idle(5);

    phase = "double_strobe";
    run_cycle(1'b1, 1'b0, 1'b0, 25'd5, 2'b00, 16'hFFFF, acc);
    idle(3);
    issue(1'b1, 5, 2'b11, 16'h0000);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
